// File: rtl/scan_display_mux.sv
// -----------------------------------------------------------------------------
// scan_display_mux
//   Time-multiplexed scanner for DIGITS 4-bit display digits. Each digit gets
//   one slot of SLOT = BLANK + 16*SLICE clocks. The first BLANK clocks of every
//   slot keep all selects off (anti-ghosting). After that the selected digit is
//   lit for (bright+1)*SLICE clocks. Leading zero digits can be suppressed.
//   in/bright/lz_en are snapshotted once per frame, so a frame never tears.
//
// Ports
//   clk0    in   1          system clock
//   rst     in   1          synchronous reset, active-high
//   ena     in   1          1 = display on; 0 = selects off, scanning continues
//   in      in   4*DIGITS   digit codes, digit k = in[4k+3:4k]
//   bright  in   4          duty level, on-time = (bright+1)*SLICE clocks
//   lz_en   in   1          1 = blank leading zero digits (digit 0 never)
//   out     out  4          code of the active digit, 4'b1111 when idle
//   sel     out  DIGITS     active-low digit select, one-cold or all ones
//   frame   out  1          one-cycle pulse after each snapshot load
// -----------------------------------------------------------------------------
module scan_display_mux #(
    parameter int DIGITS = 4,
    parameter int BLANK  = 2,
    parameter int SLICE  = 256
) (
    input  logic                  clk0,
    input  logic                  rst,
    input  logic                  ena,
    input  logic [4*DIGITS-1:0]   in,
    input  logic [3:0]            bright,
    input  logic                  lz_en,
    output logic [3:0]            out,
    output logic [DIGITS-1:0]     sel,
    output logic                  frame
);

    localparam int SLOT  = BLANK + 16 * SLICE;
    localparam int CNT_W = $clog2(SLOT);
    localparam int IDX_W = $clog2(DIGITS);

    logic [CNT_W-1:0]    cnt_reg, cnt_next;
    logic [IDX_W-1:0]    idx_reg, idx_next;
    logic [4*DIGITS-1:0] snap_in_reg;
    logic [3:0]          snap_br_reg;
    logic                snap_lz_reg;
    logic                first_reg;
    logic                frame_reg;
    logic [DIGITS-1:0]   sel_reg, sel_next;
    logic [3:0]          out_reg, out_next;

    logic                cnt_last;
    logic                idx_last;
    logic                load;
    logic [DIGITS-1:0]   zero_from;
    logic [DIGITS-1:0]   lz_blank;
    logic [CNT_W-1:0]    on_len;
    logic [CNT_W-1:0]    offset;
    logic                on;
    logic [3:0]          digit;

    assign cnt_last = (cnt_reg == CNT_W'(SLOT - 1));
    assign idx_last = (idx_reg == IDX_W'(DIGITS - 1));
    // Snapshot on the first clock after reset and at every frame boundary.
    assign load     = first_reg | (cnt_last & idx_last);

    // zero_from[k]: snapshot digits k..DIGITS-1 are all zero.
    generate
        for (genvar gi = 0; gi < DIGITS; gi++) begin : g_lz
            if (gi == DIGITS - 1) begin : g_top
                assign zero_from[gi] = (snap_in_reg[4*gi +: 4] == 4'h0);
            end else begin : g_mid
                assign zero_from[gi] = (snap_in_reg[4*gi +: 4] == 4'h0) & zero_from[gi+1];
            end
            if (gi == 0) begin : g_d0
                assign lz_blank[gi] = 1'b0;
            end else begin : g_dk
                assign lz_blank[gi] = snap_lz_reg & zero_from[gi];
            end
        end
    endgenerate

    // 16*SLICE < SLOT, so the product always fits in CNT_W bits.
    assign on_len = (CNT_W'(snap_br_reg) + CNT_W'(1)) * CNT_W'(SLICE);
    assign offset = cnt_reg - CNT_W'(BLANK);
    assign digit  = snap_in_reg[{idx_reg, 2'b00} +: 4];
    assign on     = ena && (cnt_reg >= CNT_W'(BLANK)) && (offset < on_len)
                    && !lz_blank[idx_reg];

    always_comb begin
        cnt_next = cnt_reg + CNT_W'(1);
        idx_next = idx_reg;
        if (cnt_last) begin
            cnt_next = '0;
            idx_next = idx_last ? '0 : idx_reg + IDX_W'(1);
        end
    end

    always_comb begin
        sel_next = '1;
        out_next = 4'b1111;
        if (on) begin
            sel_next = ~(DIGITS'(1) << idx_reg);
            out_next = digit;
        end
    end

    always_ff @(posedge clk0) begin
        if (rst) begin
            cnt_reg     <= '0;
            idx_reg     <= '0;
            snap_in_reg <= '0;
            snap_br_reg <= '0;
            snap_lz_reg <= 1'b0;
            first_reg   <= 1'b1;
            frame_reg   <= 1'b0;
            sel_reg     <= '1;
            out_reg     <= 4'b1111;
        end else begin
            cnt_reg   <= cnt_next;
            idx_reg   <= idx_next;
            frame_reg <= load;
            sel_reg   <= sel_next;
            out_reg   <= out_next;
            if (load) begin
                snap_in_reg <= in;
                snap_br_reg <= bright;
                snap_lz_reg <= lz_en;
                first_reg   <= 1'b0;
            end
        end
    end

    assign out   = out_reg;
    assign sel   = sel_reg;
    assign frame = frame_reg;

endmodule

// File: tb/tb_scan_display_mux.sv
// -----------------------------------------------------------------------------
// tb_scan_display_mux
//   Directed bench for scan_display_mux with DIGITS=4, BLANK=2, SLICE=2
//   (SLOT=34). A behavioural model pushes the expected registered outputs into
//   a queue before each clock edge; they are popped and compared after it.
//   Directed checks count select-low clocks per slot/digit and frame pulses.
// -----------------------------------------------------------------------------
module tb_scan_display_mux;

    localparam int DIGITS = 4;
    localparam int BLANK  = 2;
    localparam int SLICE  = 2;
    localparam int SLOT   = BLANK + 16 * SLICE;

    logic        clk0 = 1'b0;
    logic        rst;
    logic        ena;
    logic [15:0] in;
    logic [3:0]  bright;
    logic        lz_en;
    logic [3:0]  out;
    logic [3:0]  sel;
    logic        frame;

    scan_display_mux #(.DIGITS(DIGITS), .BLANK(BLANK), .SLICE(SLICE)) dut (
        .clk0   (clk0),
        .rst    (rst),
        .ena    (ena),
        .in     (in),
        .bright (bright),
        .lz_en  (lz_en),
        .out    (out),
        .sel    (sel),
        .frame  (frame)
    );

    always #5 clk0 = ~clk0;

    typedef struct {
        logic [3:0] sel;
        logic [3:0] out;
        logic       frame;
    } exp_t;

    exp_t q[$];

    int vectors = 0;
    int errors  = 0;

    // Model state
    int          m_cnt;
    int          m_idx;
    bit          m_first;
    logic [15:0] m_in;
    int          m_br;
    bit          m_lz;

    // Directed tallies
    int low_cnt;
    int frame_cnt;
    int dig_low[4];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic clear_tally();
        low_cnt   = 0;
        frame_cnt = 0;
        for (int k = 0; k < 4; k++) dig_low[k] = 0;
    endtask

    function automatic bit model_on();
        bit blank;
        blank = 1'b0;
        if (m_lz && m_idx > 0) begin
            blank = 1'b1;
            for (int k = m_idx; k < 4; k++)
                if (m_in[k*4 +: 4] != 4'h0) blank = 1'b0;
        end
        return ena && (m_cnt >= BLANK) && ((m_cnt - BLANK) < (m_br + 1) * SLICE) && !blank;
    endfunction

    task automatic step();
        exp_t e;
        bit   load;
        if (rst) begin
            e.sel   = 4'hF;
            e.out   = 4'hF;
            e.frame = 1'b0;
            m_cnt   = 0;
            m_idx   = 0;
            m_first = 1'b1;
            m_in    = '0;
            m_br    = 0;
            m_lz    = 1'b0;
        end else begin
            load = m_first || (m_cnt == SLOT - 1 && m_idx == DIGITS - 1);
            if (model_on()) begin
                e.sel = ~(4'b0001 << m_idx);
                e.out = m_in[m_idx*4 +: 4];
            end else begin
                e.sel = 4'hF;
                e.out = 4'hF;
            end
            e.frame = load;
            if (load) begin
                m_in    = in;
                m_br    = int'(bright);
                m_lz    = lz_en;
                m_first = 1'b0;
            end
            m_cnt++;
            if (m_cnt == SLOT) begin
                m_cnt = 0;
                m_idx = (m_idx + 1) % DIGITS;
            end
        end
        q.push_back(e);
        @(posedge clk0);
        #1;
        e = q.pop_front();
        chk("sel", 32'(sel), 32'(e.sel));
        chk("out", 32'(out), 32'(e.out));
        chk("frame", 32'(frame), 32'(e.frame));
        chk("one_cold", 32'($countones(~sel) <= 1), 32'd1);
        if (sel != 4'hF) low_cnt++;
        if (frame) frame_cnt++;
        for (int k = 0; k < 4; k++) if (!sel[k]) dig_low[k]++;
    endtask

    task automatic run(input int n);
        repeat (n) step();
    endtask

    initial begin
        rst    = 1'b1;
        ena    = 1'b1;
        in     = 16'h1234;
        bright = 4'd15;
        lz_en  = 1'b0;
        @(negedge clk0);
        run(2);
        rst = 1'b0;

        // Full brightness: 2 blank + 32 lit clocks per slot, one frame pulse.
        clear_tally();
        run(SLOT);
        chk("first_frame", 32'(frame_cnt), 32'd1);
        chk("b15_slot0", 32'(low_cnt), 32'd32);
        for (int s = 1; s < 4; s++) begin
            clear_tally();
            run(SLOT);
            chk("b15_slot", 32'(low_cnt), 32'd32);
        end

        // Minimum brightness: lit 2 clocks per slot once snapshotted.
        bright = 4'd0;
        run(4 * SLOT);
        for (int s = 0; s < 4; s++) begin
            clear_tally();
            run(SLOT);
            chk("b0_slot", 32'(low_cnt), 32'd2);
        end

        // Leading-zero suppression.
        bright = 4'd15;
        lz_en  = 1'b1;
        in     = 16'h0050;
        run(4 * SLOT);
        clear_tally();
        run(4 * SLOT);
        chk("lz50_d3", 32'(dig_low[3]), 32'd0);
        chk("lz50_d2", 32'(dig_low[2]), 32'd0);
        chk("lz50_d1", 32'(dig_low[1]), 32'd32);
        chk("lz50_d0", 32'(dig_low[0]), 32'd32);
        in = 16'h0000;
        run(4 * SLOT);
        clear_tally();
        run(4 * SLOT);
        chk("lz00_d1", 32'(dig_low[1]), 32'd0);
        chk("lz00_d0", 32'(dig_low[0]), 32'd32);
        chk("lz00_frame", 32'(frame_cnt), 32'd1);

        // Input change mid-frame is deferred to the next frame.
        lz_en = 1'b0;
        in    = 16'h1234;
        run(4 * SLOT);
        run(SLOT + 10);
        in = 16'hABCD;
        run(4 * SLOT - (SLOT + 10));
        clear_tally();
        run(4 * SLOT);
        chk("abcd_frame", 32'(frame_cnt), 32'd1);

        // Display disable mid-slot.
        run(10);
        ena = 1'b0;
        clear_tally();
        run(10);
        chk("ena_off_low", 32'(low_cnt), 32'd0);
        ena = 1'b1;
        run(2 * SLOT);

        // Reset mid-slot at cnt=20, idx=2.
        for (int g = 0; g < 4 * SLOT + 1; g++) begin
            if (m_cnt == 20 && m_idx == 2) break;
            step();
        end
        chk("rst_point", 32'((m_cnt == 20) && (m_idx == 2)), 32'd1);
        rst = 1'b1;
        in  = 16'h5678;
        step();
        chk("rst_sel", 32'(sel), 32'hF);
        chk("rst_out", 32'(out), 32'hF);
        rst = 1'b0;
        clear_tally();
        run(SLOT);
        chk("rst_frame", 32'(frame_cnt), 32'd1);
        chk("rst_slot0", 32'(dig_low[0]), 32'd32);
        run(3 * SLOT);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
